// File: rtl/fnd_pkg.sv
// Shared constants for the stopwatch FND display: segment codes, conversion states, digit slots.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp off.
package fnd_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

   localparam logic [1:0] DIG_CSEC1  = 2'd0;
   localparam logic [1:0] DIG_CSEC10 = 2'd1;
   localparam logic [1:0] DIG_SEC1   = 2'd2;
   localparam logic [1:0] DIG_SEC10  = 2'd3;

   function automatic logic [7:0] seg_encode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/fnd_stopwatch_display_bin2bcd.sv
// Sequential 8-bit to 2-digit BCD (double-dabble, 8 shift steps); inputs above 99 saturate to 99.
// Latency: start -> done pulse 10 clk; start is ignored unless idle.
module bin2bcd_seq
   import fnd_pkg::*;
(
   input  logic       clk,
   input  logic       reset_p,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   conv_state_t state, state_n;
   logic [7:0]  bin_sr;
   logic [7:0]  bcd_sr;
   logic [7:0]  bcd_adj;
   logic [2:0]  step;

   always_ff @(posedge clk) begin
      if (reset_p) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = LOAD;
         LOAD:    state_n = SHIFT;
         SHIFT:   if (step == 3'd7) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      done = (state == DONE);
      tens = bcd_sr[7:4];
      ones = bcd_sr[3:0];
   end

   // add-3 correction on each BCD nibble before the shift
   always_comb begin
      bcd_adj[3:0] = (bcd_sr[3:0] >= 4'd5) ? bcd_sr[3:0] + 4'd3 : bcd_sr[3:0];
      bcd_adj[7:4] = (bcd_sr[7:4] >= 4'd5) ? bcd_sr[7:4] + 4'd3 : bcd_sr[7:4];
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         bin_sr <= '0;
         bcd_sr <= '0;
         step   <= '0;
      end else if (state == LOAD) begin
         bin_sr <= (bin > 8'd99) ? 8'd99 : bin;
         bcd_sr <= '0;
         step   <= '0;
      end else if (state == SHIFT) begin
         {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
         step             <= step + 3'd1;
      end
   end

endmodule

// File: rtl/fnd_stopwatch_display.sv
// Stopwatch SS.CC on a 4-digit common-anode FND; BCD re-converted once per scan frame, digits multiplexed.
// Latency: frame_start -> new digits 10 clk, registered seg_7/com; no backpressure. FND_DP_EN adds dp separator/lap.
module fnd_stopwatch_display
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV     = 100_000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic [7:0] fnd_sec,
   input  logic [7:0] fnd_csec,
   input  logic       start_stop,
   input  logic       lap,
   output logic [7:0] seg_7,
   output logic [3:0] com
);

   localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("fnd_stopwatch_display: SCAN_DIV must be >= 4");
   end

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx, idx_n;
   logic             boot, tick, frame_start;
   logic             disp_valid, valid_n;
   logic [3:0]       disp_sec10, disp_sec1, disp_csec10, disp_csec1;
   logic [3:0]       sec10_n, sec1_n, csec10_n, csec1_n, digit;
   logic             sec_done, csec_done, conv_done;
   logic [3:0]       sec_tens, sec_ones, csec_tens, csec_ones;
   logic             dp_on;
   logic [7:0]       seg_code, seg_n;
   logic [3:0]       com_n;

   // scan stays parked on slot 0 until the first conversion lands, so the display opens on csec ones
   assign tick        = disp_valid && (cnt == CNT_MAX);
   assign frame_start = boot || (tick && idx == DIG_SEC10);
   assign idx_n       = tick ? idx + 2'd1 : idx;
   assign conv_done   = sec_done && csec_done;
   assign valid_n     = disp_valid || conv_done;

   always_ff @(posedge clk) begin
      if (reset_p) begin
         boot <= 1'b1;
         cnt  <= '0;
         idx  <= '0;
      end else begin
         boot <= 1'b0;
         idx  <= idx_n;
         if (disp_valid) cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

   bin2bcd_seq u_sec (
      .clk     (clk),
      .reset_p (reset_p),
      .start   (frame_start),
      .bin     (fnd_sec),
      .done    (sec_done),
      .tens    (sec_tens),
      .ones    (sec_ones)
   );

   bin2bcd_seq u_csec (
      .clk     (clk),
      .reset_p (reset_p),
      .start   (frame_start),
      .bin     (fnd_csec),
      .done    (csec_done),
      .tens    (csec_tens),
      .ones    (csec_ones)
   );

   always_ff @(posedge clk) begin
      if (reset_p) begin
         disp_valid  <= 1'b0;
         disp_sec10  <= '0;
         disp_sec1   <= '0;
         disp_csec10 <= '0;
         disp_csec1  <= '0;
      end else if (conv_done) begin
         disp_valid  <= 1'b1;
         disp_sec10  <= sec_tens;
         disp_sec1   <= sec_ones;
         disp_csec10 <= csec_tens;
         disp_csec1  <= csec_ones;
      end
   end

`ifdef FND_DP_EN
   localparam int               BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

   logic [BLK_W-1:0] blink_cnt;
   logic             blink_on;

   always_ff @(posedge clk) begin
      if (reset_p || !start_stop) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == BLK_MAX) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      dp_on = 1'b0;
      if (idx_n == DIG_SEC1)       dp_on = blink_on;
      else if (idx_n == DIG_CSEC1) dp_on = lap;
   end
`else
   logic unused_dp_inputs;
   assign unused_dp_inputs = start_stop ^ lap;
   assign dp_on            = 1'b0;
`endif

   // a conversion finishing this cycle feeds the output register directly, so seg and com move together
   always_comb begin
      sec10_n  = conv_done ? sec_tens  : disp_sec10;
      sec1_n   = conv_done ? sec_ones  : disp_sec1;
      csec10_n = conv_done ? csec_tens : disp_csec10;
      csec1_n  = conv_done ? csec_ones : disp_csec1;
      digit    = 4'd0;
      case (idx_n)
         DIG_CSEC1:  digit = csec1_n;
         DIG_CSEC10: digit = csec10_n;
         DIG_SEC1:   digit = sec1_n;
         default:    digit = sec10_n;
      endcase
      seg_code = seg_encode(digit);
      seg_n    = SEG_BLANK;
      com_n    = 4'b1111;
      if (valid_n) begin
         seg_n = {~dp_on, seg_code[6:0]};
         com_n = ~(4'b0001 << idx_n);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         seg_7 <= SEG_BLANK;
         com   <= 4'b1111;
      end else begin
         seg_7 <= seg_n;
         com   <= com_n;
      end
   end

endmodule

// File: tb/tb_fnd_stopwatch_display.sv
// Directed bench for fnd_stopwatch_display with SCAN_DIV=4, BLINK_FRAMES=2 (one scan frame = 16 clk).
// Build with +define+FND_DP_EN to exercise the dp separator/lap logic instead of the dp-off checks.
module tb_fnd_stopwatch_display;

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic [7:0] fnd_sec = 8'd0;
   logic [7:0] fnd_csec = 8'd0;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic [7:0] seg_7;
   logic [3:0] com;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef FND_DP_EN
   localparam logic [7:0] DP2_MASK = 8'h7F;
`else
   localparam logic [7:0] DP2_MASK = 8'hFF;
`endif

   always #5 clk = ~clk;

   fnd_stopwatch_display #(
      .SCAN_DIV     (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .fnd_sec    (fnd_sec),
      .fnd_csec   (fnd_csec),
      .start_stop (start_stop),
      .lap        (lap),
      .seg_7      (seg_7),
      .com        (com)
   );

   task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // release reset and count edges until the first digit enable appears
   task automatic wait_first_valid(input string tag, input logic [7:0] exp_seg);
      int n = 0;
      bit seen = 1'b0;
      reset_p = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         step(1);
         if (com != 4'b1111) begin
            seen = 1'b1;
            n    = i;
         end
      end
      chk_val({tag, "_lat"}, 16'(n), 16'd11);
      chk_val({tag, "_com"}, {12'd0, com}, 16'h000E);
      chk_val({tag, "_seg"}, {8'd0, seg_7}, {8'd0, exp_seg});
   endtask

   task automatic sync_frame(input string tag);
      logic [3:0] prev;
      bit found = 1'b0;
      prev = com;
      for (int i = 0; i < 48 && !found; i++) begin
         step(1);
         if (com == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = com;
      end
      chk_val({tag, "_sync"}, 16'(found), 16'd1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] exp_seg;
      logic [3:0] exp_com;
      sync_frame(tag);
      for (int d = 0; d < 4; d++) begin
         exp_com = ~(4'b0001 << d);
         case (d)
            0:       exp_seg = e0;
            1:       exp_seg = e1;
            2:       exp_seg = e2 & DP2_MASK;
            default: exp_seg = e3;
         endcase
         chk_val($sformatf("%s_com%0d", tag, d), {12'd0, com}, {12'd0, exp_com});
         chk_val($sformatf("%s_seg%0d", tag, d), {8'd0, seg_7}, {8'd0, exp_seg});
         if (d < 3) step(4);
      end
   endtask

   initial begin
      // 1: reset state and first-valid latency (00.00 -> csec ones shows 0)
      step(3);
      chk_val("rst_seg", {8'd0, seg_7}, 16'h00FF);
      chk_val("rst_com", {12'd0, com}, 16'h000F);
      wait_first_valid("boot", 8'hC0);

      // 2: 42.07
      fnd_sec  = 8'd42;
      fnd_csec = 8'd7;
      step(28);
      check_frame("t42_07", 8'hF8, 8'hC0, 8'hA4, 8'h99);

      // 3: saturation to 99.99
      fnd_sec  = 8'd200;
      fnd_csec = 8'd150;
      step(28);
      check_frame("sat", 8'h90, 8'h90, 8'h90, 8'h90);

      // 4: csec 12 -> 34 mid-frame: one more frame of 12, then 34
      fnd_sec  = 8'd0;
      fnd_csec = 8'd12;
      step(28);
      check_frame("c12", 8'hA4, 8'hF9, 8'hC0, 8'hC0);
      fnd_csec = 8'd34;
      check_frame("c12_hold", 8'hA4, 8'hF9, 8'hC0, 8'hC0);
      check_frame("c34", 8'h99, 8'hB0, 8'hC0, 8'hC0);

      // 5: reset in the middle of SHIFT, restart with 13.58
      fnd_sec  = 8'd42;
      fnd_csec = 8'd7;
      step(28);
      sync_frame("abort");
      step(4);
      reset_p  = 1'b1;
      fnd_sec  = 8'd13;
      fnd_csec = 8'd58;
      step(1);
      chk_val("abort_seg", {8'd0, seg_7}, 16'h00FF);
      chk_val("abort_com", {12'd0, com}, 16'h000F);
      wait_first_valid("restart", 8'h80);
      check_frame("r13_58", 8'h80, 8'h92, 8'hB0, 8'hF9);

      // 6: decimal points
`ifdef FND_DP_EN
      begin
         logic dp_s [4];
         start_stop = 1'b1;
         for (int f = 0; f < 4; f++) begin
            sync_frame($sformatf("blink%0d", f));
            step(8);
            chk_val($sformatf("blink%0d_com", f), {12'd0, com}, 16'h000B);
            dp_s[f] = seg_7[7];
         end
         chk_val("blink_f0_f2", 16'(dp_s[0] ^ dp_s[2]), 16'd1);
         chk_val("blink_f1_f3", 16'(dp_s[1] ^ dp_s[3]), 16'd1);
         start_stop = 1'b0;
         lap        = 1'b1;
         step(2);
         sync_frame("lap");
         chk_val("lap_dp0", 16'(seg_7[7]), 16'd0);
         step(8);
         chk_val("stop_dp2", 16'(seg_7[7]), 16'd0);
         lap = 1'b0;
      end
`else
      start_stop = 1'b1;
      lap        = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk_val($sformatf("dp_off%0d", i), 16'(seg_7[7]), 16'd1);
      end
      start_stop = 1'b0;
      lap        = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
